// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : motor_pkg
// Purpose : Shared types and widths for the step-profile scheduler.
//           STEP_W - width of step counts and position
//           PER_W  - width of pulse periods (clk cycles)
//           sched_state_t - scheduler state encoding
// Revision: 1.0 - initial release
// ============================================================================
package motor_pkg;

    localparam int STEP_W = 32;
    localparam int PER_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ACCEL  = 3'd2,
        CRUISE = 3'd3,
        DECEL  = 3'd4,
        FINISH = 3'd5
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/period_ramp.sv
`default_nettype none
// ============================================================================
// Module  : period_ramp
// Purpose : Combinational saturating period step for one pulse.
//           up = 1 : next_period = min(period + delta, bound)
//           up = 0 : next_period = max(period - delta, bound), floor at 0
// Ports   : period      - current pulse period
//           delta       - per-pulse change
//           bound       - ceiling (up) or floor (down)
//           up          - ramp direction
//           next_period - period for the following pulse
// Revision: 1.0 - initial release
// ============================================================================
module period_ramp
    import motor_pkg::*;
(
    input  logic [PER_W-1:0] period,
    input  logic [PER_W-1:0] delta,
    input  logic [PER_W-1:0] bound,
    input  logic             up,
    output logic [PER_W-1:0] next_period
);

    // One extra bit so period + delta can never wrap.
    logic [PER_W:0]   sum;
    logic [PER_W-1:0] diff;

    always_comb begin
        sum  = {1'b0, period} + {1'b0, delta};
        diff = (period > delta) ? (period - delta) : '0;
        if (up) begin
            next_period = (sum > {1'b0, bound}) ? bound : sum[PER_W-1:0];
        end else begin
            next_period = (diff < bound) ? bound : diff;
        end
    end

endmodule
`default_nettype wire

// File: rtl/step_profile_sched.sv
`default_nettype none
// ============================================================================
// Module  : step_profile_sched
// Purpose : Trapezoidal step-pulse scheduler. Accepts a move command, then
//           drives a pulse generator with a ramp-down / cruise / ramp-up
//           period profile, tracks the signed position, and strobes done.
// Ports   : clk, rst_n (async, active-low)
//           cmd_valid/cmd_ready handshake with cmd_steps, cmd_dir,
//           cmd_accel_steps, cmd_period_start, cmd_period_min,
//           cmd_period_delta
//           abort   - finish after the current pulse
//           pos_clr - clear position (wins over a same-cycle step)
//           pg_start/pg_period to the pulse generator, pg_done from it
//           dir_out, busy, done, pos
// Revision: 1.0 - initial release
// ============================================================================
module step_profile_sched
    import motor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              cmd_dir,
    input  logic [PER_W-1:0]  cmd_accel_steps,
    input  logic [PER_W-1:0]  cmd_period_start,
    input  logic [PER_W-1:0]  cmd_period_min,
    input  logic [PER_W-1:0]  cmd_period_delta,
    input  logic              abort,
    input  logic              pos_clr,
    output logic              pg_start,
    output logic [PER_W-1:0]  pg_period,
    input  logic              pg_done,
    output logic              dir_out,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] pos
);

    localparam int EXT_W = STEP_W - PER_W;

    sched_state_t state, state_nxt;

    logic [STEP_W-1:0] steps_q;
    logic [PER_W-1:0]  accel_q;
    logic [PER_W-1:0]  start_q;
    logic [PER_W-1:0]  min_q;
    logic [PER_W-1:0]  delta_q;

    logic [PER_W-1:0]  pmin_eff;
    logic [PER_W-1:0]  acc_eff;
    logic [STEP_W-1:0] decel_at;
    logic [STEP_W-1:0] cnt;
    logic              abort_q;

    logic              active;
    logic              step_ev;
    logic              last_pulse;
    logic [STEP_W-1:0] cnt_inc;
    logic [STEP_W-1:0] steps_half;
    logic [PER_W-1:0]  acc_calc;
    logic [PER_W-1:0]  pmin_calc;
    logic [STEP_W-1:0] decel_calc;
    logic              ramp_up;
    logic [PER_W-1:0]  ramp_bound;
    logic [PER_W-1:0]  ramp_next;

    period_ramp u_ramp (
        .period      (pg_period),
        .delta       (delta_q),
        .bound       (ramp_bound),
        .up          (ramp_up),
        .next_period (ramp_next)
    );

    always_comb begin
        state_nxt  = state;
        active     = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
        step_ev    = active && pg_done;
        cnt_inc    = cnt + STEP_W'(1);
        // A latched abort ends the move on the pulse that is in flight.
        last_pulse = (cnt_inc == steps_q) || abort_q;

        steps_half = steps_q >> 1;
        acc_calc   = ({{EXT_W{1'b0}}, accel_q} < steps_half) ? accel_q
                                                             : steps_half[PER_W-1:0];
        pmin_calc  = (min_q < start_q) ? min_q : start_q;
        decel_calc = steps_q - {{EXT_W{1'b0}}, acc_calc};

        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = LOAD;
            end
            LOAD: begin
                if (steps_q == '0)      state_nxt = FINISH;
                else if (acc_calc != '0) state_nxt = ACCEL;
                else                     state_nxt = CRUISE;
            end
            ACCEL: begin
                if (step_ev) begin
                    if (last_pulse)                                  state_nxt = FINISH;
                    else if (cnt_inc == decel_at)                    state_nxt = DECEL;
                    else if (cnt_inc == {{EXT_W{1'b0}}, acc_eff})    state_nxt = CRUISE;
                end
            end
            CRUISE: begin
                if (step_ev) begin
                    if (last_pulse)               state_nxt = FINISH;
                    else if (cnt_inc == decel_at) state_nxt = DECEL;
                end
            end
            DECEL: begin
                if (step_ev && last_pulse) state_nxt = FINISH;
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The first decelerating pulse already carries the raised period, so
        // the ramp-up applies on the pulse that enters DECEL as well. This
        // keeps the profile a mirror image of the acceleration ramp.
        ramp_up    = (state_nxt == DECEL);
        ramp_bound = ramp_up ? start_q : pmin_eff;

        cmd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        done       = (state == FINISH);
        pg_start   = active;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            steps_q   <= '0;
            accel_q   <= '0;
            start_q   <= '0;
            min_q     <= '0;
            delta_q   <= '0;
            dir_out   <= 1'b0;
            pmin_eff  <= '0;
            acc_eff   <= '0;
            decel_at  <= '0;
            cnt       <= '0;
            abort_q   <= 1'b0;
            pg_period <= '0;
            pos       <= '0;
        end else begin
            state <= state_nxt;

            if ((state == IDLE) && cmd_valid) begin
                steps_q   <= cmd_steps;
                accel_q   <= cmd_accel_steps;
                start_q   <= cmd_period_start;
                min_q     <= cmd_period_min;
                delta_q   <= cmd_period_delta;
                dir_out   <= cmd_dir;
                pg_period <= cmd_period_start;
            end

            if (state == LOAD) begin
                pmin_eff <= pmin_calc;
                acc_eff  <= acc_calc;
                decel_at <= decel_calc;
            end

            if (step_ev) begin
                cnt <= cnt_inc;
                if ((state == ACCEL) || ramp_up) begin
                    pg_period <= ramp_next;
                end
            end

            if (state == FINISH) begin
                cnt     <= '0;
                abort_q <= 1'b0;
            end else if (abort && (state != IDLE)) begin
                abort_q <= 1'b1;
            end

            if (pos_clr) begin
                pos <= '0;
            end else if (step_ev) begin
                pos <= dir_out ? (pos + STEP_W'(1)) : (pos - STEP_W'(1));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_profile_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_step_profile_sched
// Purpose : Self-checking bench for step_profile_sched. A behavioural model
//           predicts the per-pulse period profile and the position; a
//           compare process checks the DUT each cycle, and directed moves
//           pin the model with hand-computed values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_step_profile_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic        cmd_dir;
    logic [15:0] cmd_accel_steps;
    logic [15:0] cmd_period_start;
    logic [15:0] cmd_period_min;
    logic [15:0] cmd_period_delta;
    logic        abort;
    logic        pos_clr;
    logic        pg_start;
    logic [15:0] pg_period;
    logic        pg_done;
    logic        dir_out;
    logic        busy;
    logic        done;
    logic [31:0] pos;

    always #5 clk = ~clk;

    step_profile_sched dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_steps        (cmd_steps),
        .cmd_dir          (cmd_dir),
        .cmd_accel_steps  (cmd_accel_steps),
        .cmd_period_start (cmd_period_start),
        .cmd_period_min   (cmd_period_min),
        .cmd_period_delta (cmd_period_delta),
        .abort            (abort),
        .pos_clr          (pos_clr),
        .pg_start         (pg_start),
        .pg_period        (pg_period),
        .pg_done          (pg_done),
        .dir_out          (dir_out),
        .busy             (busy),
        .done             (done),
        .pos              (pos)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    int          exp_per[0:255];
    int          exp_len = 0;
    logic        m_dir   = 1'b0;
    logic [31:0] m_pos   = '0;
    int          m_idx   = 0;
    int          n_done  = 0;
    int          n_acc   = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    bit          pgs_hi  = 1'b0;
    int          cap[$];

    // Pulse-generator control
    bit clr_now = 1'b0;
    bit clr_arm = 1'b0;
    bit inject  = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Period profile from the move parameters: ramp down by delta to the
    // effective minimum for acc_eff pulses, hold, then mirror back up so the
    // last acc_eff pulses climb back to the start period.
    function automatic void build(input int steps, input int acc, input int start,
                                  input int mn, input int delta);
        int pmin, a, d_at, p;
        pmin = (mn < start) ? mn : start;
        a    = (acc < steps / 2) ? acc : steps / 2;
        d_at = steps - a;
        p    = start;
        exp_len = (steps > 256) ? 256 : steps;
        for (int k = 0; k < exp_len; k++) begin
            exp_per[k] = p;
            if (k + 1 >= d_at)   p = (p + delta > start) ? start : p + delta;
            else if (k + 1 <= a) p = (p - delta < pmin) ? pmin : p - delta;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse generator: one pg_done strobe every fourth cycle of pg_start.
    initial begin
        int gap;
        gap     = 0;
        pg_done = 1'b0;
        pos_clr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pg_done = 1'b0;
            if (pg_start && rst_n) begin
                gap++;
                if (gap == 4) begin
                    pg_done = 1'b1;
                    gap     = 0;
                end
            end else begin
                gap = 0;
            end
            if (inject) pg_done = 1'b1;
            pos_clr = clr_now || (clr_arm && pg_done);
            if (clr_now) clr_now = 1'b0;
            if (clr_arm && pg_done) clr_arm = 1'b0;
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_pos = '0;
                m_idx = 0;
                check("rst_pos", pos, 0);
                check("rst_pg_start", pg_start, 0);
            end else begin
                check("pos", pos, m_pos);
                if (pg_start) pgs_hi = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    n_acc++;
                    acc_cyc = cyc;
                    m_dir   = cmd_dir;
                    m_idx   = 0;
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (pg_start && pg_done) begin
                    if (m_idx < exp_len) check("period", pg_period, exp_per[m_idx]);
                    else                 check("extra_pulse", m_idx, exp_len);
                    cap.push_back(int'(pg_period));
                    m_idx++;
                    if (pos_clr)    m_pos = '0;
                    else if (m_dir) m_pos = m_pos + 32'd1;
                    else            m_pos = m_pos - 32'd1;
                end else if (pos_clr) begin
                    m_pos = '0;
                end
            end
        end
    end

    task automatic issue(input int steps, input bit dir, input int acc, input int start,
                         input int mn, input int delta, input bit hold);
        build(steps, acc, start, mn, delta);
        cap.delete();
        cmd_steps        = steps;
        cmd_dir          = dir;
        cmd_accel_steps  = acc[15:0];
        cmd_period_start = start[15:0];
        cmd_period_min   = mn[15:0];
        cmd_period_delta = delta[15:0];
        cmd_valid        = 1'b1;
        tick();
        if (!hold) begin
            cmd_valid        = 1'b0;
            cmd_steps        = 32'h0000_0003;
            cmd_dir          = ~dir;
            cmd_accel_steps  = 16'hFFFF;
            cmd_period_start = 16'h0007;
            cmd_period_min   = 16'h0001;
            cmd_period_delta = 16'h1234;
        end
    endtask

    task automatic wait_done(input int d0, input int budget);
        int i;
        i = 0;
        while (n_done == d0 && i < budget) begin
            tick();
            i++;
        end
        if (n_done == d0) check("done_timeout", 0, 1);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int i;
        i = 0;
        while (m_idx < n && i < budget) begin
            tick();
            i++;
        end
        if (m_idx < n) check("pulse_timeout", m_idx, n);
    endtask

    task automatic clear_pos();
        clr_now = 1'b1;
        tick();
        tick();
        tick();
    endtask

    int lit39[10] = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
    int lit40[5]  = '{50, 35, 20, 35, 50};

    initial begin
        int d0, a0;
        rst_n = 1'b0;  cmd_valid = 1'b0;  cmd_steps = '0;  cmd_dir = 1'b0;
        cmd_accel_steps = '0;  cmd_period_start = '0;  cmd_period_min = '0;
        cmd_period_delta = '0;  abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pg_period", pg_period, 0);
        check("rst_dir_out", dir_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Symmetric trapezoid, positive direction
        clear_pos();
        d0 = n_done;
        issue(10, 1'b1, 3, 100, 40, 20, 1'b0);
        wait_done(d0, 400);
        tick(); tick();
        check("t1_len", cap.size(), 10);
        for (int i = 0; i < 10 && i < cap.size(); i++) check("t1_period", cap[i], lit39[i]);
        check("t1_pos", $signed(pos), 10);
        check("t1_done_count", n_done - d0, 1);

        // Short move clamps acceleration, negative direction
        clear_pos();
        issue(5, 1'b0, 10, 50, 10, 15, 1'b0);
        wait_done(n_done, 300);
        check("t2_len", cap.size(), 5);
        for (int i = 0; i < 5 && i < cap.size(); i++) check("t2_period", cap[i], lit40[i]);
        check("t2_pos", $signed(pos), -5);
        check("t2_dir_out", dir_out, 0);

        // Zero-length move
        pgs_hi = 1'b0;
        d0 = n_done;
        issue(0, 1'b1, 3, 100, 40, 20, 1'b0);
        wait_done(d0, 20);
        check("t3_latency", done_cyc - acc_cyc, 2);
        check("t3_pg_start_seen", pgs_hi, 0);
        check("t3_pos", $signed(pos), -5);

        // Abort during pulse 4 of a long move
        clear_pos();
        d0 = n_done;
        issue(100, 1'b1, 10, 100, 40, 5, 1'b0);
        wait_pulses(3, 200);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(d0, 200);
        check("t4_pulses", m_idx, 4);
        check("t4_pos", $signed(pos), 4);
        check("t4_ready", cmd_ready, 1);
        check("t4_busy", busy, 0);

        // Minimum above start, command held valid through the move
        clear_pos();
        a0 = n_acc;
        d0 = n_done;
        issue(6, 1'b1, 2, 100, 200, 10, 1'b1);
        wait_done(d0, 300);
        cmd_valid = 1'b0;
        tick();
        check("t5_len", cap.size(), 6);
        for (int i = 0; i < cap.size(); i++) check("t5_period", cap[i], 100);
        check("t5_accepts", n_acc - a0, 1);
        check("t5_pos", $signed(pos), 6);

        // Zero delta: constant period
        issue(8, 1'b0, 3, 60, 20, 0, 1'b0);
        wait_done(n_done, 300);
        check("t6_len", cap.size(), 8);
        for (int i = 0; i < cap.size(); i++) check("t6_period", cap[i], 60);

        // Single-step move, no acceleration possible
        issue(1, 1'b1, 5, 77, 10, 5, 1'b0);
        wait_done(n_done, 100);
        check("t7_len", cap.size(), 1);
        if (cap.size() > 0) check("t7_period", cap[0], 77);

        // pos_clr coinciding with the first step
        clear_pos();
        clr_arm = 1'b1;
        issue(6, 1'b1, 2, 50, 30, 10, 1'b0);
        wait_done(n_done, 300);
        check("t8_pos", $signed(pos), 5);

        // pg_done in IDLE is ignored
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick(); tick();
        check("t9_pos", $signed(pos), 5);
        check("t9_busy", busy, 0);

        // Reset in the middle of cruise
        issue(40, 1'b1, 2, 30, 10, 10, 1'b0);
        wait_pulses(5, 200);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        check("t10_pg_start", pg_start, 0);
        check("t10_busy", busy, 0);
        check("t10_pos", pos, 0);
        check("t10_pg_period", pg_period, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check("t10_no_done", n_done - d0, 0);
        check("t10_ready", cmd_ready, 1);
        issue(3, 1'b1, 1, 20, 10, 5, 1'b0);
        wait_done(d0, 100);
        check("t10_new_pos", $signed(pos), 3);
        check("t10_new_done", n_done - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/step_profile_sched.md
STEP_PROFILE_SCHED -- requirements
Module: step_profile_sched

Interface
REQ-001 SHALL have clk, input, 1: clock; all logic on the rising edge.
REQ-002 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have cmd_valid, input, 1: move command offered.
REQ-004 SHALL have cmd_ready, output, 1: command accepted when cmd_valid && cmd_ready.
REQ-005 SHALL have cmd_steps, input, 32: total pulses in the move.
REQ-006 SHALL have cmd_dir, input, 1: 1 = positive direction, 0 = negative.
REQ-007 SHALL have cmd_accel_steps, input, 16: requested acceleration pulse count.
REQ-008 SHALL have cmd_period_start, input, 16: first and last pulse period, in clk cycles.
REQ-009 SHALL have cmd_period_min, input, 16: cruise period.
REQ-010 SHALL have cmd_period_delta, input, 16: period change per pulse during ramps.
REQ-011 SHALL have abort, input, 1: finish after the current pulse.
REQ-012 SHALL have pos_clr, input, 1: synchronous clear of pos.
REQ-013 SHALL have pg_start, output, 1: enables the pulse generator.
REQ-014 SHALL have pg_period, output, 16: period of the current pulse.
REQ-015 SHALL have pg_done, input, 1: one-cycle strobe marking the end of each generated pulse.
REQ-016 SHALL have dir_out, output, 1: latched cmd_dir.
REQ-017 SHALL have busy, output, 1: move in progress (state != IDLE).
REQ-018 SHALL have done, output, 1: one-cycle strobe at move completion.
REQ-019 SHALL have pos, output, 32: signed position; wraps modulo 2^32.

Function
REQ-020 SHALL implement states IDLE, LOAD, ACCEL, CRUISE, DECEL, FINISH.
REQ-021 SHALL drive cmd_ready = 1 only in IDLE, and SHALL latch all cmd_* fields on acceptance, then enter LOAD.
- Command fields SHALL be ignored outside acceptance.
REQ-022 In LOAD, SHALL compute the effective values:
- pmin_eff = min(cmd_period_min, cmd_period_start).
- acc_eff = min(cmd_accel_steps, cmd_steps/2).
- decel_at = cmd_steps - acc_eff.
REQ-023 LOAD SHALL exit as follows:
- If cmd_steps == 0: go to FINISH with no pulses issued.
- Otherwise: go to ACCEL if acc_eff > 0, else CRUISE.
- First pulse: pg_period = cmd_period_start; pg_start = 1 from the cycle after LOAD.
REQ-024 pg_start SHALL be 1 only in ACCEL, CRUISE and DECEL.
REQ-025 On each pg_done in an active state, SHALL do the following in the same edge:
- Increment the 32-bit pulse counter cnt.
- Update pos by +1 or -1 per dir_out.
- Update pg_period (see REQ-026 to REQ-028).
REQ-026 ACCEL SHALL set pg_period = max(pg_period - delta, pmin_eff), computed saturating with no underflow.
- SHALL go to CRUISE when cnt+1 == acc_eff.
- SHALL go to DECEL directly when cnt+1 == decel_at.
REQ-027 CRUISE SHALL hold pg_period and SHALL go to DECEL when cnt+1 == decel_at.
REQ-028 DECEL SHALL set pg_period = min(pg_period + delta, cmd_period_start), with a 17-bit intermediate so the sum cannot wrap.
REQ-029 Any active state SHALL go to FINISH when cnt+1 == cmd_steps; this takes priority over every other transition.
REQ-030 SHALL latch abort while busy. On the next pg_done after the latch, SHALL go to FINISH, and that pulse SHALL still be counted.
REQ-031 FINISH SHALL:
- Drive done = 1 for exactly one cycle.
- Clear cnt and the abort latch.
- Return to IDLE the following cycle.
REQ-032 pg_done SHALL be ignored in IDLE, LOAD and FINISH.
REQ-033 pos_clr SHALL have priority over a simultaneous pg_done update; the result is pos = 0.
REQ-034 cmd_period_delta == 0 SHALL yield a constant-period move that still walks through the ACCEL/CRUISE/DECEL states.

Reset
REQ-035 While rst_n = 0, SHALL hold:
- State IDLE.
- cmd_ready = 1.
- pg_start = 0, pg_period = 0.
- dir_out = 0, busy = 0, done = 0.
- pos = 0, cnt = 0, abort latch = 0.
REQ-036 Reset mid-move SHALL drop pg_start asynchronously, SHALL discard the move, and SHALL not assert done.

Structure
REQ-037 SHALL take the state enum and the width constants (STEP_W = 32, PER_W = 16) from the shared package motor_pkg.
REQ-038 SHALL instantiate one sub-module, period_ramp: combinational saturating period step (inputs: period, delta, bound, up/down; output: next period).

Verification
REQ-039 Move steps=10, accel=3, start=100, min=40, delta=20 -> pg_period sequence 100,80,60,40,40,40,40,60,80,100; one done strobe; pos = +10.
REQ-040 steps=5, accel=10, start=50, min=10, delta=15, dir=0 -> acc_eff = 2; periods 50,35,20,35,50; pos = -5.
REQ-041 steps=0 -> done exactly 2 cycles after acceptance; pg_start never asserted; pos unchanged.
REQ-042 abort asserted during pulse 4 of a 100-step move -> exactly 4 pg_done counted, done strobe, back in IDLE, cmd_ready = 1.
REQ-043 min=200 > start=100 -> all periods 100; cmd_valid held during the move -> no second acceptance until IDLE.
REQ-044 rst_n low mid-CRUISE -> pg_start = 0 immediately, no done strobe, pos = 0; a new command is accepted after release.
